// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared types and widths for the PWM measurement block.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int DUTY_W = 11;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_meas_state_t;

    typedef logic [DUTY_W-1:0] duty_t;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sync_edge
// Brief    : Synchronises the PWM input and produces level, rise and fall.
//            Optional glitch filter enabled by PWM_GLITCH_FILT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_sync_edge #(
    parameter int SYNC_STG = 2,
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pwm,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STG-1:0] r_sync;
    logic                w_pwm_s;
    logic                w_level;
    logic                r_pwm_q;

    if (SYNC_STG < 2 || FILT_LEN < 1) begin : g_param_check
        $error("pwm_sync_edge: SYNC_STG must be >= 2 and FILT_LEN >= 1");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], i_pwm};
        end
    end

    assign w_pwm_s = r_sync[SYNC_STG-1];

`ifdef PWM_GLITCH_FILT_EN
    localparam int c_fcnt_w = $clog2(FILT_LEN + 1);

    logic [c_fcnt_w-1:0] r_fcnt;
    logic                r_filt;

    // Level flips only on the FILT_LEN-th consecutive differing sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fcnt <= '0;
            r_filt <= 1'b0;
        end else if (w_pwm_s == r_filt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == c_fcnt_w'(FILT_LEN - 1)) begin
            r_fcnt <= '0;
            r_filt <= w_pwm_s;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = w_pwm_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm_q <= 1'b0;
        end else begin
            r_pwm_q <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_pwm_q;
    assign o_fall  = ~w_level & r_pwm_q;

endmodule : pwm_sync_edge
`default_nettype wire

// File: rtl/pwm_meas.sv
`default_nettype none
// ============================================================================
// Module   : pwm_meas
// Brief    : Measures high time and period of an asynchronous PWM input and
//            flags a stuck line. Optional glitch filter: PWM_GLITCH_FILT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_meas #(
    parameter int DUTY_W   = pwm_pkg::DUTY_W,
    parameter int SYNC_STG = 2,
    parameter int FILT_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PWM_in,
    output logic [DUTY_W-1:0] duty,
    output logic [DUTY_W:0]   period,
    output logic              vld,
    output logic              stuck
);

    import pwm_pkg::*;

    localparam int                c_cnt_w    = DUTY_W + 1;
    localparam logic [DUTY_W:0]   c_cnt_max  = '1;
    localparam logic [DUTY_W-1:0] c_duty_max = '1;

    logic              w_level;
    logic              w_rise;
    logic              w_fall;
    pwm_meas_state_t   r_state;
    pwm_meas_state_t   w_state_nxt;
    logic [DUTY_W:0]   r_hi_cnt;
    logic [DUTY_W:0]   r_lo_cnt;
    logic [DUTY_W:0]   r_idle;
    logic [DUTY_W:0]   w_hi_nxt;
    logic [DUTY_W:0]   w_lo_nxt;
    logic [DUTY_W:0]   w_idle_nxt;
    logic              w_report;
    logic              w_timeout;
    logic [DUTY_W+1:0] w_sum;
    logic [DUTY_W-1:0] w_duty_meas;
    logic [DUTY_W:0]   w_period_meas;

    pwm_sync_edge #(
        .SYNC_STG (SYNC_STG),
        .FILT_LEN (FILT_LEN)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .i_pwm   (PWM_in),
        .o_level (w_level),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi_cnt;
        w_lo_nxt    = r_lo_cnt;
        w_report    = 1'b0;
        case (r_state)
            SYNC: begin
                if (w_rise) begin
                    w_state_nxt = HIGH;
                    w_hi_nxt    = c_cnt_w'(1);
                    w_lo_nxt    = '0;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_state_nxt = LOW;
                    w_lo_nxt    = c_cnt_w'(1);
                end else if (r_hi_cnt != c_cnt_max) begin
                    w_hi_nxt = r_hi_cnt + 1'b1;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_report    = 1'b1;
                    w_state_nxt = HIGH;
                    w_hi_nxt    = c_cnt_w'(1);
                    w_lo_nxt    = '0;
                end else if (r_lo_cnt != c_cnt_max) begin
                    w_lo_nxt = r_lo_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = SYNC;
            end
        endcase

        // Any edge clears the idle counter, so a rise always beats the timeout.
        w_timeout = 1'b0;
        if (w_rise || w_fall) begin
            w_idle_nxt = '0;
        end else if (r_idle != c_cnt_max) begin
            w_idle_nxt = r_idle + 1'b1;
            w_timeout  = (w_idle_nxt == c_cnt_max);
        end else begin
            w_idle_nxt = r_idle;
        end

        if (w_timeout) begin
            w_state_nxt = SYNC;
            w_hi_nxt    = '0;
            w_lo_nxt    = '0;
        end
    end

    assign w_sum         = {1'b0, r_hi_cnt} + {1'b0, r_lo_cnt};
    assign w_period_meas = w_sum[c_cnt_w] ? c_cnt_max : w_sum[c_cnt_w-1:0];
    assign w_duty_meas   = r_hi_cnt[c_cnt_w-1] ? c_duty_max : r_hi_cnt[DUTY_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi_cnt <= '0;
            r_lo_cnt <= '0;
            r_idle   <= '0;
            duty     <= '0;
            period   <= '0;
            vld      <= 1'b0;
            stuck    <= 1'b0;
        end else begin
            r_hi_cnt <= w_hi_nxt;
            r_lo_cnt <= w_lo_nxt;
            r_idle   <= w_idle_nxt;
            vld      <= w_report | w_timeout;
            if (w_report) begin
                duty   <= w_duty_meas;
                period <= w_period_meas;
                stuck  <= 1'b0;
            end else if (w_timeout) begin
                duty   <= w_level ? c_duty_max : '0;
                period <= c_cnt_max;
                stuck  <= 1'b1;
            end
        end
    end

endmodule : pwm_meas
`default_nettype wire

// File: tb/tb_pwm_meas.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_meas
// Brief    : Randomised scoreboard bench for pwm_meas; expected reports come
//            from a segment-level model of the PWM waveform.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_meas;

    import pwm_pkg::*;

    localparam int c_duty_max = (1 << DUTY_W) - 1;
    localparam int c_per_max  = (1 << (DUTY_W + 1)) - 1;
    localparam int c_to_len   = c_per_max + 1;
`ifdef PWM_GLITCH_FILT_EN
    localparam int c_min_seg  = 4;
`else
    localparam int c_min_seg  = 1;
`endif

    typedef struct {
        int duty;
        int period;
        int stuck;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            PWM_in = 1'b0;
    duty_t           duty;
    logic [DUTY_W:0] period;
    logic            vld;
    logic            stuck;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // Segment-level model state
    bit m_valid  = 1'b0;
    bit m_have_l = 1'b0;
    int m_h      = 0;
    int m_l      = 0;

    pwm_meas u_dut (
        .clk    (clk),
        .rst    (rst),
        .PWM_in (PWM_in),
        .duty   (duty),
        .period (period),
        .vld    (vld),
        .stuck  (stuck)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_valid  = 1'b0;
        m_have_l = 1'b0;
    endfunction

    // A high segment starts with a rise, closing any complete high+low pair.
    // Any segment lasting a full idle timeout produces a stuck report.
    function automatic void model_seg(input bit lvl, input int n);
        exp_t e;
        if (lvl) begin
            if (m_valid && m_have_l) begin
                e.duty   = (m_h > c_duty_max) ? c_duty_max : m_h;
                e.period = (m_h + m_l > c_per_max) ? c_per_max : m_h + m_l;
                e.stuck  = 0;
                exp_q.push_back(e);
            end
            m_valid  = 1'b1;
            m_h      = n;
            m_have_l = 1'b0;
        end else if (m_valid) begin
            m_l      = n;
            m_have_l = 1'b1;
        end
        if (n >= c_to_len) begin
            e.duty   = lvl ? c_duty_max : 0;
            e.period = c_per_max;
            e.stuck  = 1;
            exp_q.push_back(e);
            m_valid  = 1'b0;
        end
    endfunction

    task automatic drive_seg(input bit lvl, input int n);
        model_seg(lvl, n);
        PWM_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && vld) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_vld: duty=%0d period=%0d stuck=%0d, required no vld",
                         duty, period, stuck);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (int'(duty) != e.duty || int'(period) != e.period || int'(stuck) != e.stuck) begin
                    n_fail++;
                    $display("FAIL meas: got duty=%0d period=%0d stuck=%0d, required duty=%0d period=%0d stuck=%0d",
                             duty, period, stuck, e.duty, e.period, e.stuck);
                end
            end
        end
    end

    initial begin
        int sweep [3];
        sweep[0] = c_min_seg;
        sweep[1] = 1024;
        sweep[2] = 2048 - c_min_seg;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_duty",   int'(duty),   0);
        check("rst_period", int'(period), 0);
        check("rst_vld",    int'(vld),    0);
        check("rst_stuck",  int'(stuck),  0);
        rst = 1'b0;
        drive_seg(1'b0, 100);

        // 25% duty at period 2048
        repeat (4) begin
            drive_seg(1'b1, 512);
            drive_seg(1'b0, 1536);
        end

        // Duty sweep including the extreme pulse widths
        for (int i = 0; i < 3; i++) begin
            repeat (2) begin
                drive_seg(1'b1, sweep[i]);
                drive_seg(1'b0, 2048 - sweep[i]);
            end
        end

        // Line stuck low, then recovery
        drive_seg(1'b1, 1024);
        drive_seg(1'b0, 5000);
        check("stuck_low_level", int'(stuck), 1);
        drive_seg(1'b1, 1024);
        drive_seg(1'b0, 1024);
        drive_seg(1'b1, 1024);
        check("stuck_cleared", int'(stuck), 0);

        // Line stuck high
        drive_seg(1'b0, 1024);
        drive_seg(1'b1, 5000);
        check("stuck_high_level", int'(stuck), 1);
        drive_seg(1'b0, 1000);

        // Duty clamp and period saturation
        drive_seg(1'b1, 2500);
        drive_seg(1'b0, 1800);
        drive_seg(1'b1, 3000);
        drive_seg(1'b0, 1000);
        drive_seg(1'b1, 700);
        drive_seg(1'b0, 700);

        // Random waveform
        repeat (16) begin
            drive_seg(1'b1, $urandom_range(1000, c_min_seg));
            drive_seg(1'b0, $urandom_range(1000, c_min_seg));
        end

        // Short low glitch inside a 600-cycle high phase
`ifdef PWM_GLITCH_FILT_EN
        model_seg(1'b1, 600);
        PWM_in = 1'b1;
        repeat (300) @(negedge clk);
        PWM_in = 1'b0;
        repeat (2) @(negedge clk);
        PWM_in = 1'b1;
        repeat (298) @(negedge clk);
`else
        drive_seg(1'b1, 300);
        drive_seg(1'b0, 2);
        drive_seg(1'b1, 298);
`endif
        drive_seg(1'b0, 500);
        drive_seg(1'b1, 400);
        drive_seg(1'b0, 300);

        // Reset in the middle of a high phase
        model_seg(1'b1, 800);
        PWM_in = 1'b1;
        repeat (400) @(negedge clk);
        rst    = 1'b1;
        PWM_in = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_duty",   int'(duty),   0);
        check("midrst_period", int'(period), 0);
        check("midrst_vld",    int'(vld),    0);
        check("midrst_stuck",  int'(stuck),  0);
        check("midrst_queue",  exp_q.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive_seg(1'b0, 300);
        drive_seg(1'b1, 700);
        drive_seg(1'b0, 900);
        drive_seg(1'b1, 600);
        drive_seg(1'b0, 400);

        // Every expected report must have been seen
        drive_seg(1'b0, 20);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pwm_meas
`default_nettype wire
